mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache and dcache line transfers onto one request/response bus.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; the default build gives the dcache fixed priority.
module mem_arbiter #(
    parameter int WIDTH = 64,
    parameter int BEATS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ic_req,
    input  logic [WIDTH-1:0] ic_addr,
    output logic             ic_gnt,
    output logic             ic_data_valid,
    output logic [WIDTH-1:0] ic_data,
    output logic             ic_done,
    input  logic             dc_req,
    input  logic             dc_we,
    input  logic [WIDTH-1:0] dc_addr,
    input  logic [WIDTH-1:0] dc_wdata,
    output logic             dc_gnt,
    output logic             dc_data_valid,
    output logic [WIDTH-1:0] dc_data,
    output logic             dc_done,
    output logic             dc_wnext,
    output logic             bus_reqcyc,
    output logic [WIDTH-1:0] bus_req,
    input  logic             bus_reqack,
    input  logic             bus_respcyc,
    input  logic [WIDTH-1:0] bus_resp,
    output logic             bus_respack
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [WIDTH-1:0] LINE_KEEP = {{(WIDTH-6){1'b1}}, 6'b0};

    typedef enum logic [2:0] {IDLE, ISSUE, WDATA, RESP, DONE} state_t;
    typedef enum logic {OWN_IC, OWN_DC} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, win;
    logic              we_q;
    logic [WIDTH-1:0]  addr_q;
    logic [CW-1:0]     cnt_q;
    logic              last_beat;

`ifdef MEM_ARB_RR_EN
    owner_t last_owner;

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_owner <= OWN_IC;
        end else if (state_q == DONE) begin
            last_owner <= owner_q;
        end
    end
`endif

    // A lone requester always wins; the macro only decides simultaneous requests.
    always_comb begin
        win = OWN_IC;
        if (dc_req) begin
`ifdef MEM_ARB_RR_EN
            win = (ic_req && last_owner == OWN_DC) ? OWN_IC : OWN_DC;
`else
            win = OWN_DC;
`endif
        end
    end

    assign last_beat = (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_respack = 1'b0;
        dc_wnext    = 1'b0;
        ic_done     = 1'b0;
        dc_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) state_d = ISSUE;
            end
            ISSUE: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                if (bus_reqack) state_d = we_q ? WDATA : RESP;
            end
            WDATA: begin
                bus_reqcyc = 1'b1;
                bus_req    = dc_wdata;
                dc_wnext   = bus_reqack;
                if (bus_reqack && last_beat) state_d = DONE;
            end
            RESP: begin
                bus_respack = bus_respcyc;
                if (bus_respcyc && last_beat) state_d = DONE;
            end
            DONE: begin
                ic_done = (owner_q == OWN_IC);
                dc_done = (owner_q == OWN_DC);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q       <= OWN_IC;
            we_q          <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            ic_gnt        <= 1'b0;
            dc_gnt        <= 1'b0;
            ic_data_valid <= 1'b0;
            dc_data_valid <= 1'b0;
            ic_data       <= '0;
            dc_data       <= '0;
        end else begin
            ic_gnt        <= 1'b0;
            dc_gnt        <= 1'b0;
            ic_data_valid <= 1'b0;
            dc_data_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        owner_q <= win;
                        we_q    <= (win == OWN_DC) && dc_we;
                        addr_q  <= ((win == OWN_DC) ? dc_addr : ic_addr) & LINE_KEEP;
                        ic_gnt  <= (win == OWN_IC);
                        dc_gnt  <= (win == OWN_DC);
                    end
                end
                ISSUE: begin
                    if (bus_reqack) cnt_q <= '0;
                end
                WDATA: begin
                    if (bus_reqack && !last_beat) cnt_q <= cnt_q + CW'(1);
                end
                RESP: begin
                    if (bus_respcyc) begin
                        if (owner_q == OWN_IC) begin
                            ic_data       <= bus_resp;
                            ic_data_valid <= 1'b1;
                        end else begin
                            dc_data       <= bus_resp;
                            dc_data_valid <= 1'b1;
                        end
                        if (!last_beat) cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed line-fill/write-back/arbitration/reset scenarios, then randomized traffic.
module tb_mem_arbiter;
    localparam int WIDTH = 64;
    localparam int BEATS = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ic_req = 1'b0;
    logic [63:0] ic_addr = '0;
    logic        ic_gnt, ic_data_valid, ic_done;
    logic [63:0] ic_data;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [63:0] dc_addr = '0;
    logic [63:0] dc_wdata = '0;
    logic        dc_gnt, dc_data_valid, dc_done, dc_wnext;
    logic [63:0] dc_data;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic        bus_reqack = 1'b0;
    logic        bus_respcyc = 1'b0;
    logic [63:0] bus_resp = '0;
    logic        bus_respack;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(WIDTH), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_data_valid(ic_data_valid),
        .ic_data(ic_data), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_data_valid(dc_data_valid), .dc_data(dc_data), .dc_done(dc_done),
        .dc_wnext(dc_wnext),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_respack(bus_respack)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Reference model: one transaction at a time, tracked as address-sent flag plus beats moved.
    bit          m_init, m_busy, m_own, m_wr, m_sent, m_fin, m_gnt, m_vld, m_last;
    int          m_beats;
    logic [63:0] m_addr, m_vdata;

    int          gnt_log[$];
    logic [63:0] ic_beats[$];
    logic [63:0] req_log[$];
    int          wnext_cnt, respack_cnt, ic_done_cnt, dc_done_cnt, resp_idx;

    function automatic bit pick(input bit i, input bit d, input bit last);
        if (!d) return 1'b0;
        if (!i) return 1'b1;
`ifdef MEM_ARB_RR_EN
        return !last;
`else
        return 1'b1;
`endif
    endfunction

    initial begin : compare
        bit act, e_reqcyc;
        forever begin
            @(negedge clk);
            if (m_init) begin
                act      = m_busy && !m_fin;
                e_reqcyc = act && (!m_sent || m_wr);
                chk("bus_reqcyc", bus_reqcyc, e_reqcyc);
                if (e_reqcyc) chk("bus_req", bus_req, m_sent ? dc_wdata : m_addr);
                chk("bus_respack", bus_respack, act && m_sent && !m_wr && bus_respcyc);
                chk("dc_wnext", dc_wnext, act && m_sent && m_wr && bus_reqack);
                chk("ic_gnt", ic_gnt, m_gnt && !m_own);
                chk("dc_gnt", dc_gnt, m_gnt && m_own);
                chk("ic_data_valid", ic_data_valid, m_vld && !m_own);
                chk("dc_data_valid", dc_data_valid, m_vld && m_own);
                if (m_vld && !m_own) chk("ic_data", ic_data, m_vdata);
                if (m_vld && m_own) chk("dc_data", dc_data, m_vdata);
                chk("ic_done", ic_done, m_fin && !m_own);
                chk("dc_done", dc_done, m_fin && m_own);
            end
            if (ic_gnt === 1'b1) gnt_log.push_back(0);
            if (dc_gnt === 1'b1) gnt_log.push_back(1);
            if (ic_data_valid === 1'b1) ic_beats.push_back(ic_data);
            if (bus_reqcyc === 1'b1) req_log.push_back(bus_req);
            if (dc_wnext === 1'b1) wnext_cnt++;
            if (bus_respack === 1'b1) begin
                respack_cnt++;
                resp_idx++;
            end
            if (ic_done === 1'b1) ic_done_cnt++;
            if (dc_done === 1'b1) dc_done_cnt++;
            // advance to the state the next clock edge produces
            if (!reset) begin
                m_init = 1'b1; m_busy = 1'b0; m_sent = 1'b0; m_fin = 1'b0;
                m_gnt = 1'b0; m_vld = 1'b0; m_last = 1'b0; m_own = 1'b0; m_beats = 0;
            end else begin
                m_gnt = 1'b0;
                m_vld = 1'b0;
                if (m_fin) begin
                    m_fin  = 1'b0;
                    m_busy = 1'b0;
                    m_last = m_own;
                end else if (!m_busy) begin
                    if (ic_req || dc_req) begin
                        m_own   = pick(ic_req, dc_req, m_last);
                        m_wr    = m_own && dc_we;
                        m_addr  = (m_own ? dc_addr : ic_addr) & ~64'h3f;
                        m_busy  = 1'b1;
                        m_sent  = 1'b0;
                        m_beats = 0;
                        m_gnt   = 1'b1;
                    end
                end else if (!m_sent) begin
                    if (bus_reqack) m_sent = 1'b1;
                end else if (m_wr) begin
                    if (bus_reqack) begin
                        m_beats++;
                        if (m_beats == BEATS) m_fin = 1'b1;
                    end
                end else if (bus_respcyc) begin
                    m_vld   = 1'b1;
                    m_vdata = bus_resp;
                    m_beats++;
                    if (m_beats == BEATS) m_fin = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        gnt_log.delete();
        ic_beats.delete();
        req_log.delete();
        wnext_cnt = 0; respack_cnt = 0; ic_done_cnt = 0; dc_done_cnt = 0; resp_idx = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic drive_bus(input int ack_pct, input int resp_pct);
        bus_reqack  = ($urandom_range(99) < ack_pct);
        bus_respcyc = ($urandom_range(99) < resp_pct);
        bus_resp    = 64'(resp_idx);
        dc_wdata    = 64'h100 + 64'(wnext_cnt);
    endtask

    task automatic run_txn(input string name, input bit want_ic, input bit want_dc, input bit we,
                           input logic [63:0] ia, input logic [63:0] da, input int ack_pct,
                           input int resp_pct, input bit drop_after_gnt, input bit first_only);
        bit ic_pend, dc_pend, fin;
        ic_pend = want_ic; dc_pend = want_dc; fin = 1'b0;
        ic_req = want_ic; dc_req = want_dc; dc_we = we; ic_addr = ia; dc_addr = da;
        drive_bus(ack_pct, resp_pct);
        for (int n = 0; n < 300 && !fin; n++) begin
            step();
            if (ic_done) begin
                ic_pend = 1'b0; ic_req = 1'b0;
                if (first_only) begin dc_pend = 1'b0; dc_req = 1'b0; end
            end
            if (dc_done) begin
                dc_pend = 1'b0; dc_req = 1'b0;
                if (first_only) begin ic_pend = 1'b0; ic_req = 1'b0; end
            end
            if (drop_after_gnt && ic_gnt) ic_req = 1'b0;
            if (drop_after_gnt && dc_gnt) dc_req = 1'b0;
            fin = !ic_pend && !dc_pend;
            drive_bus(ack_pct, resp_pct);
        end
        chk({name, "_complete"}, fin, 1'b1);
        ic_req = 1'b0; dc_req = 1'b0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
        step();
        step();
    endtask

    initial begin : main
        bit ic_act, dc_act;
        do_reset();
        chk("reset_outputs", {bus_reqcyc, bus_respack, ic_gnt, ic_data_valid, ic_done,
                              dc_gnt, dc_data_valid, dc_done, dc_wnext}, '0);
        chk("reset_data", ic_data | dc_data, '0);

        // icache line fill, immediate ack, back-to-back beats
        clear_logs();
        run_txn("ic_fill", 1, 0, 0, 64'h1234, 0, 100, 100, 0, 0);
        chk("ic_fill_beats", ic_beats.size(), 8);
        for (int i = 0; i < 8 && i < ic_beats.size(); i++) chk("ic_fill_beat", ic_beats[i], 64'(i));
        chk("ic_fill_reqs", req_log.size(), 1);
        if (req_log.size() > 0) chk("ic_fill_addr", req_log[0], 64'h1200);
        chk("ic_fill_done", ic_done_cnt, 1);
        chk("ic_fill_gnts", gnt_log.size(), 1);

        // dcache write-back with responses offered the whole time
        clear_logs();
        run_txn("dc_wb", 0, 1, 1, 0, 64'h80, 100, 100, 0, 0);
        chk("dc_wb_wnext", wnext_cnt, 8);
        chk("dc_wb_reqs", req_log.size(), 9);
        if (req_log.size() > 0) chk("dc_wb_addr", req_log[0], 64'h80);
        for (int k = 1; k < 9 && k < req_log.size(); k++) chk("dc_wb_beat", req_log[k], 64'h100 + 64'(k - 1));
        chk("dc_wb_respack", respack_cnt, 0);
        chk("dc_wb_done", dc_done_cnt, 1);

        // simultaneous requests, three rounds after reset
        do_reset();
        clear_logs();
        for (int r = 0; r < 3; r++) run_txn("both", 1, 1, 0, 64'h4000, 64'h8000, 100, 100, 0, 1);
        chk("both_gnts", gnt_log.size(), 3);
`ifdef MEM_ARB_RR_EN
        if (gnt_log.size() == 3) chk("both_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0]}, 3'b101);
`else
        if (gnt_log.size() == 3) chk("both_order", {gnt_log[0][0], gnt_log[1][0], gnt_log[2][0]}, 3'b111);
`endif

        // stray responses in IDLE, requester drops after grant, gapped beats
        clear_logs();
        bus_respcyc = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("idle_respack", bus_respack, 1'b0);
        run_txn("gaps", 1, 0, 0, 64'h5678, 0, 50, 50, 1, 0);
        chk("gaps_beats", ic_beats.size(), 8);
        chk("gaps_done", ic_done_cnt, 1);

        // reset after three read beats aborts without a done pulse
        do_reset();
        clear_logs();
        ic_req = 1'b1; ic_addr = 64'h2345;
        drive_bus(100, 100);
        for (int n = 0; n < 50 && resp_idx < 3; n++) begin
            step();
            if (resp_idx < 3) drive_bus(100, 100);
        end
        chk("abort_reached", resp_idx >= 3, 1'b1);
        reset = 1'b0; ic_req = 1'b0; bus_respcyc = 1'b0; bus_reqack = 1'b0;
        step();
        chk("abort_outputs", {bus_reqcyc, bus_respack, ic_gnt, ic_data_valid, ic_done,
                              dc_gnt, dc_data_valid, dc_done, dc_wnext}, '0);
        reset = 1'b1;
        step();
        chk("abort_no_done", ic_done_cnt, 0);
        clear_logs();
        run_txn("after_abort", 1, 0, 0, 64'h3000, 0, 100, 100, 0, 0);
        chk("after_abort_beats", ic_beats.size(), 8);
        chk("after_abort_done", ic_done_cnt, 1);

        // randomized traffic with occasional resets
        ic_act = 1'b0; dc_act = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            step();
            if ($urandom_range(399) == 0) begin
                reset = 1'b0; ic_req = 1'b0; dc_req = 1'b0; ic_act = 1'b0; dc_act = 1'b0;
            end else begin
                reset = 1'b1;
                if (ic_act) begin
                    if (ic_done) begin ic_act = 1'b0; ic_req = 1'b0; end
                    else if (ic_gnt && $urandom_range(2) == 0) ic_req = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    ic_act = 1'b1; ic_req = 1'b1; ic_addr = {$urandom, $urandom};
                end
                if (dc_act) begin
                    if (dc_done) begin dc_act = 1'b0; dc_req = 1'b0; end
                    else if (dc_gnt && $urandom_range(2) == 0) dc_req = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    dc_act = 1'b1; dc_req = 1'b1; dc_we = 1'($urandom_range(1));
                    dc_addr = {$urandom, $urandom};
                end
            end
            bus_reqack  = 1'($urandom_range(1));
            bus_respcyc = 1'($urandom_range(1));
            bus_resp    = {$urandom, $urandom};
            dc_wdata    = {$urandom, $urandom};
        end
        reset = 1'b1; ic_req = 1'b0; dc_req = 1'b0;
        for (int i = 0; i < 20; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
